// File: rtl/r_ptr_gen.sv
// Read-side pointer, address and empty-flag generator for the 10-deep BIST FIFO.
// Johnson read pointer, 2-flop write-pointer synchronizer, underflow blocking and sticky error flags.
module r_ptr_gen #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic [SIZE:0]   w_ptr_i,
  input  logic            clr_err_i,
  output logic            r_en_o,
  output logic [SIZE-1:0] r_addr_o,
  output logic [SIZE:0]   r_ptr_o,
  output logic            r_empty_o,
  output logic            underflow_o,
  output logic            ptr_err_o
);

  logic [SIZE-1:0] r_addr_q, r_addr_d;
  logic [SIZE:0]   r_ptr_q, r_ptr_d;
  logic [SIZE:0]   ws1_q, ws2_q;
  logic            r_empty_q, r_empty_d;
  logic            underflow_q, underflow_d;
  logic            ptr_err_q, ptr_err_d;
  logic            acc;
  logic [SIZE-1:0] trans;
  logic            ws2_legal;

  // A Johnson code has at most one boundary between adjacent bits.
  assign trans     = ws2_q[SIZE:1] ^ ws2_q[SIZE-1:0];
  assign ws2_legal = (trans & (trans - SIZE'(1))) == '0;

  assign acc = inc_i & ~r_empty_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    r_addr_d    = r_addr_q;
    r_ptr_d     = r_ptr_q;
    if (acc) begin
      r_addr_d = (r_addr_q == SIZE'(DEPTH - 1)) ? '0 : r_addr_q + SIZE'(1);
      r_ptr_d  = {r_ptr_q[SIZE-1:0], ~r_ptr_q[SIZE]};
    end
    // Compare the pointer we are about to hold, so the last read raises empty on its own edge.
    r_empty_d   = (r_ptr_d == ws2_q);
    underflow_d = clr_err_i ? 1'b0 : (underflow_q | (inc_i & r_empty_q));
    ptr_err_d   = clr_err_i ? 1'b0 : (ptr_err_q | ~ws2_legal);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ws1_q       <= '0;
      ws2_q       <= '0;
      r_addr_q    <= '0;
      r_ptr_q     <= '0;
      r_empty_q   <= 1'b1;
      underflow_q <= 1'b0;
      ptr_err_q   <= 1'b0;
    end else begin
      ws1_q       <= w_ptr_i;
      ws2_q       <= ws1_q;
      r_addr_q    <= r_addr_d;
      r_ptr_q     <= r_ptr_d;
      r_empty_q   <= r_empty_d;
      underflow_q <= underflow_d;
      ptr_err_q   <= ptr_err_d;
    end
  end

  assign r_en_o      = acc;
  assign r_addr_o    = r_addr_q;
  assign r_ptr_o     = r_ptr_q;
  assign r_empty_o   = r_empty_q;
  assign underflow_o = underflow_q;
  assign ptr_err_o   = ptr_err_q;

endmodule
